// File: rtl/pulse_sequencer_if.sv
// Instruction-push channel into the pulse sequencer: valid/ready handshake
// carrying one packed pulse instruction per transfer.
interface pulse_sequencer_if #(
  parameter int INST_W = 96
) ();
  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] in_inst;

  modport master (
    output in_valid,
    output in_inst,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_inst,
    output in_ready
  );
endinterface

// File: rtl/pulse_sequencer.sv
// Timed pulse sequencer: buffers packed pulse instructions in a small FIFO and
// plays the head entry once the local timebase reaches its start time, holding
// the decoded fields on the output for the pulse length.
module pulse_sequencer #(
  parameter int FREQ_W   = 16,
  parameter int PHASE_W  = 16,
  parameter int AMP_W    = 16,
  parameter int TSTART_W = 32,
  parameter int TLEN_W   = 16,
  parameter int DEPTH    = 8,
  localparam int INST_W  = FREQ_W + PHASE_W + AMP_W + TSTART_W + TLEN_W,
  localparam int LVL_W   = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                timer_en,
  pulse_sequencer_if.slave    in_if,
  output logic [TSTART_W-1:0] time_now,
  output logic [LVL_W-1:0]    level,
  output logic                out_active,
  output logic                out_start,
  output logic                out_done,
  output logic [FREQ_W-1:0]   out_freq,
  output logic [PHASE_W-1:0]  out_phase,
  output logic [AMP_W-1:0]    out_amp,
  output logic                late_err
);

  localparam int AW      = $clog2(DEPTH);
  localparam int PH_LSB  = FREQ_W;
  localparam int AMP_LSB = FREQ_W + PHASE_W;
  localparam int TS_LSB  = FREQ_W + PHASE_W + AMP_W;
  localparam int LEN_LSB = FREQ_W + PHASE_W + AMP_W + TSTART_W;

  typedef enum logic {IDLE, PLAY} state_t;

  // FIFO storage and pointers
  logic [INST_W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q;
  logic [AW-1:0]       rd_ptr_q;
  logic [LVL_W-1:0]    count_q;
  logic [LVL_W-1:0]    count_d;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;

  // Head-entry decode
  logic [INST_W-1:0]   head;
  logic [FREQ_W-1:0]   head_freq;
  logic [PHASE_W-1:0]  head_phase;
  logic [AMP_W-1:0]    head_amp;
  logic [TSTART_W-1:0] head_tstart;
  logic [TLEN_W-1:0]   head_tlen;
  logic [TSTART_W-1:0] time_diff;
  logic                due;
  logic                slot_free;
  logic                issue;

  // Timebase and playback state
  logic [TSTART_W-1:0] time_q;
  state_t              state_q;
  logic [TLEN_W-1:0]   rem_q;
  logic                active_q;
  logic                start_q;
  logic                done_q;
  logic [FREQ_W-1:0]   freq_q;
  logic [PHASE_W-1:0]  phase_q;
  logic [AMP_W-1:0]    amp_q;
  logic                late_q;

  assign full  = (count_q == LVL_W'(DEPTH));
  assign empty = (count_q == '0);

  // in_ready looks only at the registered occupancy, so a pop this cycle
  // never opens a slot early.
  assign in_if.in_ready = !full;

  assign head        = mem_q[rd_ptr_q];
  assign head_freq   = head[FREQ_W-1:0];
  assign head_phase  = head[PH_LSB  +: PHASE_W];
  assign head_amp    = head[AMP_LSB +: AMP_W];
  assign head_tstart = head[TS_LSB  +: TSTART_W];
  assign head_tlen   = head[LEN_LSB +: TLEN_W];

  // Wrap-aware "start time reached": modular difference is non-negative.
  assign time_diff = time_q - head_tstart;
  assign due       = !time_diff[TSTART_W-1];
  assign slot_free = (state_q == IDLE) || (rem_q == TLEN_W'(1));
  assign issue     = !empty && slot_free && due;

  assign push = in_if.in_valid && !full && !clear;
  assign pop  = issue && !clear;

  // Occupancy next-state: simultaneous push and pop cancel out
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and occupancy, flushed by clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // FIFO data array; contents are only meaningful behind the pointers
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_if.in_inst;
  end

  // Free-running timebase, zeroed by clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_q <= '0;
    end else if (clear) begin
      time_q <= '0;
    end else if (timer_en) begin
      time_q <= time_q + TSTART_W'(1);
    end
  end

  // Playback FSM: issue, length countdown, strobes, field latch, late flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      active_q <= 1'b0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      freq_q   <= '0;
      phase_q  <= '0;
      amp_q    <= '0;
      late_q   <= 1'b0;
    end else if (clear) begin
      // Abort without a done strobe; last fields stay on the outputs.
      state_q  <= IDLE;
      rem_q    <= '0;
      active_q <= 1'b0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      late_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      if (issue && (head_tlen != '0)) begin
        state_q  <= PLAY;
        rem_q    <= head_tlen;
        active_q <= 1'b1;
        start_q  <= 1'b1;
        done_q   <= (head_tlen == TLEN_W'(1));
        freq_q   <= head_freq;
        phase_q  <= head_phase;
        amp_q    <= head_amp;
      end else if (state_q == PLAY) begin
        // A zero-length pop lands here too, so a finishing pulse ends normally.
        if (rem_q == TLEN_W'(1)) begin
          state_q  <= IDLE;
          rem_q    <= '0;
          active_q <= 1'b0;
        end else begin
          rem_q  <= rem_q - TLEN_W'(1);
          done_q <= (rem_q == TLEN_W'(2));
        end
      end
      if (issue && (time_q != head_tstart)) late_q <= 1'b1;
    end
  end

  assign time_now   = time_q;
  assign level      = count_q;
  assign out_active = active_q;
  assign out_start  = start_q;
  assign out_done   = done_q;
  assign out_freq   = freq_q;
  assign out_phase  = phase_q;
  assign out_amp    = amp_q;
  assign late_err   = late_q;

endmodule

// File: doc/pulse_sequencer.md
# pulse_sequencer

Parametrised, timed successor to the pulse-instruction field decoder. Accepts packed pulse instructions over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. Decodes each entry into frequency/phase/amplitude fields and plays it on a per-cycle output strobe when the local timebase reaches the entry's start time, holding it for its length. Sits between the core's pulse-register write path and the waveform generator (NCO/DAC front end).

## Interface
Parameters:
- FREQ_W, 16, frequency field width
- PHASE_W, 16, phase field width
- AMP_W, 16, amplitude field width
- TSTART_W, 32, start-time field and timebase width
- TLEN_W, 16, pulse-length field width
- DEPTH, 8, FIFO entries; power of two, >= 2
- INST_W (derived, not overridable): FREQ_W+PHASE_W+AMP_W+TSTART_W+TLEN_W

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush
- timer_en  in  1  timebase advance enable
- in_valid  in  1  instruction offered
- in_ready  out  1  FIFO can accept; equals !full
- in_inst  in  INST_W  packed instruction, LSB first: freq [FREQ_W-1:0], then phase, amp, t_start, t_len (MSBs)
- time_now  out  TSTART_W  current timebase value
- level  out  $clog2(DEPTH+1)  FIFO occupancy
- out_active  out  1  pulse playing
- out_start  out  1  one-cycle strobe, first active cycle
- out_done  out  1  one-cycle strobe, last active cycle
- out_freq / out_phase / out_amp  out  field widths  fields of the playing pulse; held after it ends
- late_err  out  1  sticky: a pulse issued after its t_start

## Operation
- Push when in_valid && in_ready && !clear. When full, in_ready is 0 even if a pop occurs that cycle.
- time_now increments by 1 per cycle when timer_en; wraps modulo 2^TSTART_W.
- FSM states: IDLE and PLAY. A remaining-length counter of width TLEN_W tracks PLAY.
- Issue condition, evaluated in the current cycle:
  - FIFO non-empty;
  - state is IDLE, or PLAY with remaining == 1;
  - MSB of (time_now − head.t_start), taken modulo 2^TSTART_W, is 0. That is, start time reached, signed wrap-aware.
- On issue:
  - Pop head.
  - If t_len > 0: latch fields to out_*, set remaining = t_len, go to PLAY.
  - If t_len == 0: pop silently; no strobes; state unchanged, except a pulse finishing this cycle still ends normally.
- Late issue: if time_now ≠ head.t_start at issue, set late_err. The pulse still plays at full length.
- PLAY: remaining decrements each cycle. When remaining == 1 and no issue occurs, return to IDLE.
- clear:
  - Empties the FIFO and zeroes time_now.
  - Aborts any playing pulse: out_active is 0 next cycle, and no out_done is issued.
  - Clears late_err.
  - Has priority over push and issue.
- Reset: FIFO empty and state IDLE. time_now, level, all out_* and late_err are 0. in_ready is 1 once rst_n is deasserted.

## Timing
- Push to earliest issue: an entry pushed in cycle N is head-visible in cycle N+1.
- Issue in cycle N:
  - out_active = 1 for cycles N+1 .. N+t_len;
  - out_start = 1 in N+1;
  - out_done = 1 in N+t_len; when t_len == 1, out_start and out_done are both 1 in N+1;
  - out_* fields are valid from N+1.
- Back-to-back: an issue in the last PLAY cycle gives a gapless follow-on. out_done of the old pulse and out_start of the new pulse fall in adjacent cycles.
- All outputs are registered, except in_ready, which is combinational from FIFO state.
- level updates the cycle after push or pop. A simultaneous push and pop leaves level unchanged.

## Test plan
- Single pulse: timer_en=1 from reset, push {t_start=10, t_len=4, freq=0x1234} → out_start when time_now=11, out_active for 4 cycles, out_freq=0x1234, late_err=0.
- Back-to-back: push {t_start=5, len=3} and {t_start=6, len=2} → 5 contiguous active cycles, out_done then out_start in adjacent cycles, late_err=1 from the second pulse.
- Full FIFO: timer_en=0, push DEPTH+2 entries → in_ready=0 after DEPTH pushes, level=DEPTH, extra entries not stored.
- Wrap: TSTART_W=8, time_now preloaded by running to 250, push t_start=3 → no early issue; issues when time_now=3 after wrap.
- Zero length: push {t_start=2, len=0} followed by {t_start=2, len=1} → first entry consumed with no strobe, second plays 1 cycle with out_start=out_done=1.
- clear mid-pulse: assert clear on the 2nd of 5 active cycles → out_active=0 next cycle, no out_done, level=0, time_now=0, late_err=0.
